// File: rtl/sr595_chain_drv.sv
// Serial driver for a chain of 74HC595 shift registers: shifts a WIDTH-bit word out on ds/clk595,
// pulses lclk to latch it, and captures the chain's serial return (q7s) into rdata.
module sr595_chain_drv #(
  parameter int WIDTH     = 16,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1,
  parameter int LCLK_W    = 2
) (
  input  logic             ifclk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             q7s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             ds,
  output logic             clk595,
  output logic             lclk
);

  localparam int BW   = $clog2(WIDTH);
  localparam int PMAX = (DIV > LCLK_W) ? DIV : LCLK_W;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [PW-1:0] DIV_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] LCLK_LAST = PW'(LCLK_W - 1);

  typedef enum logic [2:0] {IDLE, LO, HI, LATCH, DONE} state_t;

  state_t           state, next_state;
  logic [PW-1:0]    phase;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sreg, sreg_next;
  logic [WIDTH-1:0] cap, cap_next;
  logic             accept, phase_end, last_bit, advance, sample, ds_next;
  logic             busy_d, done_d, clk595_d, lclk_d;

  assign accept   = start && (state == IDLE || state == DONE);
  assign last_bit = (bit_cnt == BIT_LAST);
  assign advance  = (state == HI) && phase_end && !last_bit;
  assign sample   = (state == LO) && phase_end;

  always_comb begin
    case (state)
      LO, HI:  phase_end = (phase == DIV_LAST);
      LATCH:   phase_end = (phase == LCLK_LAST);
      default: phase_end = 1'b0;
    endcase
  end

  always_ff @(posedge ifclk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LO;
      LO:      if (phase_end) next_state = HI;
      HI:      if (phase_end) next_state = last_bit ? LATCH : LO;
      LATCH:   if (phase_end) next_state = DONE;
      DONE:    next_state = start ? LO : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state and then registered, so each pin is a flop
  // that already shows the new state's value in the state's first cycle.
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    clk595_d = 1'b0;
    lclk_d   = 1'b0;
    case (next_state)
      LO:      busy_d = 1'b1;
      HI:      begin busy_d = 1'b1; clk595_d = 1'b1; end
      LATCH:   begin busy_d = 1'b1; lclk_d = 1'b1; end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // The shift register rotates rather than shifts so the head bit is always ds for the next LO.
  always_comb begin
    if (accept)              sreg_next = din;
    else if (MSB_FIRST != 0) sreg_next = {sreg[WIDTH-2:0], sreg[WIDTH-1]};
    else                     sreg_next = {sreg[0], sreg[WIDTH-1:1]};
    ds_next = (MSB_FIRST != 0) ? sreg_next[WIDTH-1] : sreg_next[0];
    if (MSB_FIRST != 0) cap_next = {cap[WIDTH-2:0], q7s};
    else                cap_next = {q7s, cap[WIDTH-1:1]};
  end

  // NOTE: all state below uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      phase   <= '0;
      bit_cnt <= '0;
      sreg    <= '0;
      cap     <= '0;
      rdata   <= '0;
      ds      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      clk595  <= 1'b0;
      lclk    <= 1'b0;
    end else begin
      busy   <= busy_d;
      done   <= done_d;
      clk595 <= clk595_d;
      lclk   <= lclk_d;

      if (state != next_state || state == IDLE) phase <= '0;
      else                                      phase <= phase + 1'b1;

      if (accept || advance) begin
        sreg <= sreg_next;
        ds   <= ds_next;
      end

      if (accept)       bit_cnt <= '0;
      else if (advance) bit_cnt <= bit_cnt + 1'b1;

      if (accept)      cap <= '0;
      else if (sample) cap <= cap_next;

      if (next_state == DONE) rdata <= cap;
    end
  end

endmodule
